// File: rtl/uart_pkg.sv
// Shared UART definitions: the framer FSM state encoding, the line idle level and parity helpers.
// The receiver and the bench agents use this package as well.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    localparam logic UART_IDLE_LVL = 1'b1;

    localparam logic PAR_MODE_EVEN = 1'b0;
    localparam logic PAR_MODE_ODD  = 1'b1;

    // Widest legal frame is 9 data bits; narrower words are zero-extended, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tick_det.sv
// Turns the baud clock (already synchronous to clk) into a one-clk pulse on each rising edge.
module uart_tick_det (
    input  logic clk,
    input  logic rst,
    input  logic tx_clk,
    output logic tick
);

    logic tx_clk_q_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_clk_q_reg <= 1'b0;
        end else begin
            tx_clk_q_reg <= tx_clk;
        end
    end

    assign tick = tx_clk & ~tx_clk_q_reg;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, one or two stop bits,
// each bit one tx_clk period long. All outputs are registered.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_clk,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

    state_t            state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [3:0]        bit_cnt_reg;
    logic              stop_cnt_reg;
    logic              parity_reg;
    logic              tick;

    uart_tick_det u_tick_det (
        .clk    (clk),
        .rst    (rst),
        .tx_clk (tx_clk),
        .tick   (tick)
    );

    // tx is driven one step ahead: each transition loads the level of the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            parity_reg   <= 1'b0;
            tx           <= UART_IDLE_LVL;
            tx_ready     <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx <= UART_IDLE_LVL;
                    if (tx_valid && tx_ready) begin
                        shift_reg  <= tx_data;
                        parity_reg <= calc_parity(9'(tx_data), PAR_MODE);
                        tx_ready   <= 1'b0;
                        tx_busy    <= 1'b1;
                        state_reg  <= ARM;
                    end
                end
                // A tick coinciding with the accept is seen in IDLE, so ARM always waits a fresh edge.
                ARM: begin
                    if (tick) begin
                        tx        <= 1'b0;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx          <= shift_reg[0];
                        bit_cnt_reg <= '0;
                        state_reg   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg   <= {1'b0, shift_reg[DATA_W-1:1]};
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'(DATA_W - 1)) begin
                            if (PARITY_EN != 0) begin
                                tx        <= parity_reg;
                                state_reg <= PARITY;
                            end else begin
                                tx           <= UART_IDLE_LVL;
                                stop_cnt_reg <= 1'b0;
                                state_reg    <= STOP;
                            end
                        end else begin
                            tx <= shift_reg[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx           <= UART_IDLE_LVL;
                        stop_cnt_reg <= 1'b0;
                        state_reg    <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_cnt_reg == 1'(STOP_BITS - 1)) begin
                            tx_done   <= 1'b1;
                            tx_ready  <= 1'b1;
                            tx_busy   <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            stop_cnt_reg <= stop_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    tx        <= UART_IDLE_LVL;
                    tx_ready  <= 1'b1;
                    tx_busy   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
